// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared constants and types for the PWM duty conditioning path.
//   ramp_dir_t    : ramp-state encoding driven on the dir output
//   PWM_WIDTH     : duty / switch width shared with the PWM generator
//   PWM_DB_CYCLES : default debounce length in clk cycles
//   PWM_TICK_DIV  : default clk cycles per ramp tick
package pwm_pkg;

    localparam int PWM_WIDTH     = 8;
    localparam int PWM_DB_CYCLES = 100000;
    localparam int PWM_TICK_DIV  = 50000;

    typedef enum logic [1:0] {
        RAMP_IDLE = 2'b00,
        RAMP_UP   = 2'b01,
        RAMP_DOWN = 2'b10
    } ramp_dir_t;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if
// Switch-side inputs and duty-side outputs of pwm_duty_ramp.
//   master : drives sw / bypass, observes duty, target, at_target, dir
//   slave  : the ramp block itself
interface pwm_duty_ramp_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
);

    logic [WIDTH-1:0] sw;
    logic             bypass;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] target;
    logic             at_target;
    logic [1:0]       dir;

    modport master (
        output sw, bypass,
        input  duty, target, at_target, dir
    );

    modport slave (
        input  sw, bypass,
        output duty, target, at_target, dir
    );

endinterface

// File: rtl/sw_debounce.sv
// sw_debounce
// Two-flop synchroniser followed by a whole-word debouncer. A switch word
// becomes the target only after the synchronised value has matched the
// candidate for DB_CYCLES consecutive compares.
//   clk, clr_n  : clock, async active-low reset
//   sw          : raw asynchronous switch bank
//   target      : debounced switch word (registered)
//   target_nxt  : value target takes at the next edge, so the parent can
//                 register flags that line up with target
module sw_debounce
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH,
    parameter int DB_CYCLES = PWM_DB_CYCLES
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] target_nxt
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;

    always_comb begin
        target_nxt = target;
        if ((s == cand) && (cnt == CNT_LAST)) begin
            target_nxt = cand;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1     <= '0;
            s      <= '0;
            cand   <= '0;
            cnt    <= '0;
            target <= '0;
        end else begin
            s1     <= sw;
            s      <= s1;
            target <= target_nxt;
            // Any bit change restarts the count; the count parks at its
            // last value so a long-stable word keeps reloading target.
            if (s != cand) begin
                cand <= s;
                cnt  <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
// Debounces the switch bank into a target duty and slews the duty output
// toward it by at most STEP per prescaler tick. bypass loads the target
// straight into duty every cycle.
//   clk, clr_n     : clock, async active-low reset
//   bus.sw         : raw switch bank
//   bus.bypass     : load target into duty every cycle
//   bus.duty       : registered duty to the PWM generator
//   bus.target     : debounced switch value
//   bus.at_target  : duty == target (registered, aligned with duty)
//   bus.dir        : ramp state (aligned with duty)
//
// state      | meaning
// RAMP_IDLE  | duty equals target
// RAMP_UP    | duty below target, ticks raise it
// RAMP_DOWN  | duty above target, ticks lower it
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH,
    parameter int DB_CYCLES = PWM_DB_CYCLES,
    parameter int TICK_DIV  = PWM_TICK_DIV,
    parameter int STEP      = 1
) (
    input  logic            clk,
    input  logic            clr_n,
    pwm_duty_ramp_if.slave  bus
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
    localparam int             WP1      = WIDTH + 1;
    localparam logic [WIDTH:0] STEP_W   = WP1'(STEP);

    logic [PW-1:0]    pre;
    logic             tick;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_nxt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] duty_nxt;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] delta;
    logic             at_target_q;
    ramp_dir_t        dir_q;

    sw_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .clr_n      (clr_n),
        .sw         (bus.sw),
        .target     (target),
        .target_nxt (target_nxt)
    );

    assign tick = (pre == PRE_LAST);

    function automatic ramp_dir_t dir_of(input logic [WIDTH-1:0] d,
                                         input logic [WIDTH-1:0] t);
        if (d < t)      return RAMP_UP;
        else if (d > t) return RAMP_DOWN;
        else            return RAMP_IDLE;
    endfunction

    // Step is clamped to the remaining distance, taken in WIDTH+1 bits, so
    // duty lands exactly on target and can never wrap past either rail.
    always_comb begin
        diff     = '0;
        delta    = '0;
        duty_nxt = duty;
        if (bus.bypass) begin
            duty_nxt = target;
        end else if (tick) begin
            if (duty < target) begin
                diff     = {1'b0, target} - {1'b0, duty};
                delta    = (diff < STEP_W) ? diff[WIDTH-1:0] : STEP_W[WIDTH-1:0];
                duty_nxt = duty + delta;
            end else if (duty > target) begin
                diff     = {1'b0, duty} - {1'b0, target};
                delta    = (diff < STEP_W) ? diff[WIDTH-1:0] : STEP_W[WIDTH-1:0];
                duty_nxt = duty - delta;
            end
        end
    end

    // Flags come from next-state values so they carry no lag versus duty.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre         <= '0;
            duty        <= '0;
            at_target_q <= 1'b1;
            dir_q       <= RAMP_IDLE;
        end else begin
            pre         <= tick ? '0 : pre + 1'b1;
            duty        <= duty_nxt;
            at_target_q <= (duty_nxt == target_nxt);
            dir_q       <= dir_of(duty_nxt, target_nxt);
        end
    end

    assign bus.duty      = duty;
    assign bus.target    = target;
    assign bus.at_target = at_target_q;
    assign bus.dir       = dir_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp
// Directed stimulus for pwm_duty_ramp with a window-based reference model
// compared on every falling edge, plus literal expectations at key points.
`timescale 1ns/1ps
module tb_pwm_duty_ramp;

    localparam int W  = 8;
    localparam int DB = 4;
    localparam int TD = 2;
    localparam int ST = 16;

    logic clk = 1'b0;
    logic clr_n;
    int   total = 0;
    int   bad   = 0;
    int   ecnt;

    pwm_duty_ramp_if #(.WIDTH(W)) bus ();

    pwm_duty_ramp #(
        .WIDTH     (W),
        .DB_CYCLES (DB),
        .TICK_DIV  (TD),
        .STEP      (ST)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; tick edges are those with odd index.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // target follows the synchronised switch word once the last DB+1
    // synchronised samples are identical; duty moves toward target by at
    // most ST on every TD-th edge, or jumps to it when bypass is high.
    int m_duty, m_target, m_s1, m_s, m_edges;
    int m_win [DB+1];

    task automatic m_reset();
        m_duty = 0; m_target = 0; m_s1 = 0; m_s = 0; m_edges = 0;
        for (int i = 0; i <= DB; i++) m_win[i] = 0;
    endtask

    task automatic m_step();
        int d, t;
        bit tk, stable;
        tk = ((m_edges % TD) == TD - 1);
        m_edges++;
        d = m_duty;
        t = m_target;
        if (bus.bypass) d = t;
        else if (tk) begin
            if (t > d)      d = (t - d > ST) ? d + ST : t;
            else if (d > t) d = (d - t > ST) ? d - ST : t;
        end
        for (int i = 0; i < DB; i++) m_win[i] = m_win[i+1];
        m_win[DB] = m_s;
        m_s  = m_s1;
        m_s1 = int'(bus.sw);
        stable = 1'b1;
        for (int i = 0; i < DB; i++) if (m_win[i] != m_win[DB]) stable = 1'b0;
        if (stable) t = m_win[DB];
        m_duty   = d;
        m_target = t;
    endtask

    function automatic int m_dir();
        if (m_duty == m_target) return 0;
        else if (m_duty < m_target) return 1;
        else return 2;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge clr_n);
            if (!clr_n) m_reset();
            else        m_step();
        end
    end

    always @(negedge clk) begin
        chk("model_duty",      int'(bus.duty),      m_duty);
        chk("model_target",    int'(bus.target),    m_target);
        chk("model_at_target", int'(bus.at_target), (m_duty == m_target) ? 1 : 0);
        chk("model_dir",       int'(bus.dir),       m_dir());
    end

    // ---------------- stimulus ----------------
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_duty(input int val, input int budget, input string name);
        int n;
        n = 0;
        while (int'(bus.duty) != val && n < budget) begin
            edges(1);
            n++;
        end
        chk(name, int'(bus.duty), val);
    endtask

    task automatic chk_out(input string name, input int d, input int t, input int at, input int dr);
        chk({name, "_duty"},      int'(bus.duty),      d);
        chk({name, "_target"},    int'(bus.target),    t);
        chk({name, "_at_target"}, int'(bus.at_target), at);
        chk({name, "_dir"},       int'(bus.dir),       dr);
    endtask

    initial begin
        bus.sw     = '0;
        bus.bypass = 1'b0;
        clr_n      = 1'b1;
        #1 clr_n = 1'b0;
        #1 chk_out("reset_async", 0, 0, 1, 0);
        edges(3);
        clr_n = 1'b1;
        edges(10);
        chk_out("reset_release", 0, 0, 1, 0);

        // debounce latency and up-ramp
        bus.sw = 8'h80;
        edges(6);
        chk("db_before", int'(bus.target), 0);
        edges(1);
        chk("db_load", int'(bus.target), 8'h80);
        chk("db_load_duty", int'(bus.duty), 0);
        edges(14);
        chk("ramp_mid_duty", int'(bus.duty), 8'h70);
        chk("ramp_mid_dir", int'(bus.dir), 1);
        edges(2);
        chk_out("ramp_done", 8'h80, 8'h80, 1, 0);

        // glitch reject
        bus.sw = 8'hFF;
        edges(3);
        bus.sw = 8'h80;
        edges(12);
        chk_out("glitch", 8'h80, 8'h80, 1, 0);

        // no overshoot, then full down-ramp
        bus.sw = 8'h85;
        edges(7);
        chk("small_target", int'(bus.target), 8'h85);
        edges(2);
        chk("small_step", int'(bus.duty), 8'h85);
        bus.sw = 8'h00;
        edges(7);
        chk("down_target", int'(bus.target), 0);
        edges(2);
        chk("down_first", int'(bus.duty), 8'h75);
        edges(16);
        chk_out("down_done", 0, 0, 1, 0);

        // reversal: align so the target load lands on a non-tick edge
        if ((ecnt % 2) != 0) edges(1);
        bus.sw = 8'h60;
        edges(7);
        chk("rev_load", int'(bus.target), 8'h60);
        edges(1);
        chk("rev_first", int'(bus.duty), 8'h10);
        bus.sw = 8'h20;
        edges(6);
        chk_out("rev_at40", 8'h40, 8'h60, 0, 1);
        edges(1);
        chk_out("rev_turn", 8'h40, 8'h20, 0, 2);
        edges(1);
        chk("rev_30", int'(bus.duty), 8'h30);
        edges(2);
        chk_out("rev_20", 8'h20, 8'h20, 1, 0);

        // bypass
        bus.sw = 8'hF0;
        edges(7);
        chk_out("byp_load", 8'h20, 8'hF0, 0, 1);
        bus.bypass = 1'b1;
        edges(1);
        chk_out("byp_jump", 8'hF0, 8'hF0, 1, 0);
        bus.bypass = 1'b0;

        // saturation at full scale
        bus.sw = 8'hFF;
        edges(7);
        chk_out("sat_load", 8'hF0, 8'hFF, 0, 1);
        edges(2);
        chk_out("sat_step", 8'hFF, 8'hFF, 1, 0);
        edges(4);
        chk("sat_hold", int'(bus.duty), 8'hFF);

        // reset mid-ramp
        bus.sw = 8'h00;
        wait_duty(0, 60, "fall_to_zero");
        bus.sw = 8'h80;
        wait_duty(8'h60, 40, "rise_to_60");
        clr_n = 1'b0;
        #1 chk_out("mid_reset", 0, 0, 1, 0);
        edges(2);
        clr_n = 1'b1;
        edges(6);
        chk_out("post_reset_hold", 0, 0, 1, 0);
        edges(1);
        chk_out("post_reset_load", 0, 8'h80, 0, 1);
        edges(1);
        chk("post_reset_ramp", int'(bus.duty), 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
